// File: rtl/kbd_pia.sv
// Keyboard PIA: PS/2 set-2 scan codes -> 7-bit ASCII -> character FIFO -> Apple-1 KBD/KBDCR.
// Optional macro KBD_EXTCODE_EN enables decoding of E0-prefixed cursor/navigation keys.
module kbd_pia #(
  parameter logic [15:0] BASE_ADR   = 16'hD010,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLOCK_50,
  input  logic        res,
  input  logic [7:0]  code_in,
  input  logic        code_stb,
  input  logic [15:0] cpu_adr,
  input  logic        rw,
  input  logic        acc_stb,
  output logic        sel,
  output logic [7:0]  dbo,
  output logic        kbd_avail,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] CR_ADR = BASE_ADR + 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic        shift, shift_nxt, ctrl, ctrl_nxt;
  logic        emit;
  logic [6:0]  emit_chr;
  logic [7:0]  xl;
  logic        pend_vld;
  logic [6:0]  pend_chr;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [6:0]    last_chr;
  logic          ovf;
  logic          rd_kbd, rd_cr, pop, full, push_ok, drop;

  // Returns {hit, ascii}; hit=0 for keys without a printable/control mapping.
  function automatic logic [7:0] xlate(input logic [7:0] c, input logic sh, input logic ct);
    logic [6:0] letter;
    logic [7:0] r;
    r      = 8'h00;
    letter = 7'h00;
    case (c)
      8'h1C: letter = 7'h41; 8'h32: letter = 7'h42; 8'h21: letter = 7'h43;
      8'h23: letter = 7'h44; 8'h24: letter = 7'h45; 8'h2B: letter = 7'h46;
      8'h34: letter = 7'h47; 8'h33: letter = 7'h48; 8'h43: letter = 7'h49;
      8'h3B: letter = 7'h4A; 8'h42: letter = 7'h4B; 8'h4B: letter = 7'h4C;
      8'h3A: letter = 7'h4D; 8'h31: letter = 7'h4E; 8'h44: letter = 7'h4F;
      8'h4D: letter = 7'h50; 8'h15: letter = 7'h51; 8'h2D: letter = 7'h52;
      8'h1B: letter = 7'h53; 8'h2C: letter = 7'h54; 8'h3C: letter = 7'h55;
      8'h2A: letter = 7'h56; 8'h1D: letter = 7'h57; 8'h22: letter = 7'h58;
      8'h35: letter = 7'h59; 8'h1A: letter = 7'h5A;
      8'h16: r = {1'b1, sh ? 7'h21 : 7'h31};
      8'h1E: r = {1'b1, sh ? 7'h40 : 7'h32};
      8'h26: r = {1'b1, sh ? 7'h23 : 7'h33};
      8'h25: r = {1'b1, sh ? 7'h24 : 7'h34};
      8'h2E: r = {1'b1, sh ? 7'h25 : 7'h35};
      8'h36: r = {1'b1, sh ? 7'h5E : 7'h36};
      8'h3D: r = {1'b1, sh ? 7'h26 : 7'h37};
      8'h3E: r = {1'b1, sh ? 7'h2A : 7'h38};
      8'h46: r = {1'b1, sh ? 7'h28 : 7'h39};
      8'h45: r = {1'b1, sh ? 7'h29 : 7'h30};
      8'h0E: r = {1'b1, sh ? 7'h7E : 7'h60};
      8'h4E: r = {1'b1, sh ? 7'h5F : 7'h2D};
      8'h55: r = {1'b1, sh ? 7'h2B : 7'h3D};
      8'h5D: r = {1'b1, sh ? 7'h7C : 7'h5C};
      8'h54: r = {1'b1, sh ? 7'h7B : 7'h5B};
      8'h5B: r = {1'b1, sh ? 7'h7D : 7'h5D};
      8'h4C: r = {1'b1, sh ? 7'h3A : 7'h3B};
      8'h52: r = {1'b1, sh ? 7'h22 : 7'h27};
      8'h41: r = {1'b1, sh ? 7'h3C : 7'h2C};
      8'h49: r = {1'b1, sh ? 7'h3E : 7'h2E};
      8'h4A: r = {1'b1, sh ? 7'h3F : 7'h2F};
      8'h5A: r = 8'h8D;
      8'h66: r = 8'h88;
      8'h76: r = 8'h9B;
      8'h29: r = 8'hA0;
      default: r = 8'h00;
    endcase
    // Ctrl folds letters onto 0x01-0x1A and takes priority over shift.
    if (letter != 7'h00) r = {1'b1, ct ? (letter - 7'h40) : letter};
    return r;
  endfunction

`ifdef KBD_EXTCODE_EN
  function automatic logic [7:0] xlate_ext(input logic [7:0] c);
    logic [7:0] r;
    case (c)
      8'h6B:   r = 8'h88;
      8'h74:   r = 8'h95;
      8'h75:   r = 8'h8B;
      8'h72:   r = 8'h8A;
      8'h71:   r = 8'hFF;
      default: r = 8'h00;
    endcase
    return r;
  endfunction
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!res) begin
      state    <= S_IDLE;
      shift    <= 1'b0;
      ctrl     <= 1'b0;
      pend_vld <= 1'b0;
      pend_chr <= 7'h00;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      ctrl     <= ctrl_nxt;
      pend_vld <= emit;
      pend_chr <= emit_chr;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    ctrl_nxt  = ctrl;
    emit      = 1'b0;
    emit_chr  = 7'h00;
    xl        = xlate(code_in, shift, ctrl);
    if (code_stb) begin
      case (state)
        S_IDLE: begin
          if (code_in == 8'hF0)                          state_nxt = S_BRK;
          else if (code_in == 8'hE0)                     state_nxt = S_EXT;
          else if (code_in == 8'h12 || code_in == 8'h59) shift_nxt = 1'b1;
          else if (code_in == 8'h14)                     ctrl_nxt  = 1'b1;
          else begin
            emit     = xl[7];
            emit_chr = xl[6:0];
          end
        end
        S_BRK: begin
          if (code_in == 8'h12 || code_in == 8'h59) shift_nxt = 1'b0;
          if (code_in == 8'h14)                     ctrl_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (code_in == 8'hF0) state_nxt = S_EXT_BRK;
          else begin
            state_nxt = S_IDLE;
`ifdef KBD_EXTCODE_EN
            emit     = xlate_ext(code_in)[7];
            emit_chr = xlate_ext(code_in)[6:0];
`endif
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign rd_kbd  = acc_stb && rw && (cpu_adr == BASE_ADR);
  assign rd_cr   = acc_stb && rw && (cpu_adr == CR_ADR);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_kbd && (count != '0);
  // A pop frees the slot in the same edge, so a push against a full FIFO still lands.
  assign push_ok = pend_vld && (!full || pop);
  assign drop    = pend_vld && full && !pop;

  always_ff @(posedge CLOCK_50) begin
    if (!res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_chr <= 7'h00;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_chr <= mem[rd_ptr];
      end
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (drop)       ovf <= 1'b1;
      else if (rd_cr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem[wr_ptr] <= pend_chr;
  end

  assign kbd_avail = (count != '0);
  assign overflow  = ovf;
  assign sel       = (cpu_adr == BASE_ADR) || (cpu_adr == CR_ADR);

  always_comb begin
    dbo = 8'h00;
    if (cpu_adr == BASE_ADR) dbo = kbd_avail ? {1'b1, mem[rd_ptr]} : {1'b0, last_chr};
    else if (cpu_adr == CR_ADR) dbo = {kbd_avail, ovf, 6'b0};
  end

endmodule
